// File: rtl/m_serial_adder_ctrl.sv
// Bit-serial adder: one shared 1-bit full-adder cell adds two WIDTH-bit operands LSB first,
// one bit per clock, behind a start/busy/done handshake with registered results.

module m_FA (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module m_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_start,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    input  logic             w_cin,
    output logic             r_busy,
    output logic             r_done,
    output logic [WIDTH-1:0] r_sum,
    output logic             r_cout,
    output logic             r_ovf
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             fa_sum_s, fa_co_s;
    logic [WIDTH-1:0] sh_next_s;

    m_FA u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum_s),
        .co_o (fa_co_s)
    );

    // Partial sum with the current bit inserted at the top; after WIDTH shifts it is the full sum.
    assign sh_next_s = {fa_sum_s, sh_q};

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            // DONE also samples w_start so back-to-back ops repeat every WIDTH+1 cycles.
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    a_d     = w_a;
                    b_d     = w_b;
                    sh_d    = {(WIDTH-1){1'b0}};
                    carry_d = w_cin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sh_d    = sh_next_s[WIDTH-1:1];
                carry_d = fa_co_s;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = {CW{1'b0}};
                    done_d  = 1'b1;
                    sum_d   = sh_next_s;
                    cout_d  = fa_co_s;
                    ovf_d   = carry_q ^ fa_co_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sh_q    <= {(WIDTH-1){1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign r_busy = busy_q;
    assign r_done = done_q;
    assign r_sum  = sum_q;
    assign r_cout = cout_q;
    assign r_ovf  = ovf_q;

endmodule

// File: tb/tb_m_serial_adder_ctrl.sv
// Self-checking bench for m_serial_adder_ctrl (WIDTH=8): directed and random operations
// checked against an arithmetic reference model of the last completed result.

module tb_m_serial_adder_ctrl;
    logic       w_clk = 1'b0;
    logic       w_rst_n;
    logic       w_start;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_cin;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_sum;
    logic       r_cout;
    logic       r_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the last completed result, which the DUT must hold between completions.
    logic [7:0] exp_sum  = 8'h00;
    logic       exp_cout = 1'b0;
    logic       exp_ovf  = 1'b0;

    m_serial_adder_ctrl #(.WIDTH(8)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_start (w_start),
        .w_a     (w_a),
        .w_b     (w_b),
        .w_cin   (w_cin),
        .r_busy  (r_busy),
        .r_done  (r_done),
        .r_sum   (r_sum),
        .r_cout  (r_cout),
        .r_ovf   (r_ovf)
    );

    always #5 w_clk = ~w_clk;

    // Reference: {ovf, cout, sum} from plain integer addition and two's complement sign rules.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int   full;
        logic [7:0] s;
        logic ov;
        full = int'(a) + int'(b) + int'(c);
        s    = 8'(full % 256);
        ov   = (a[7] == b[7]) && (s[7] != a[7]);
        return {ov, (full >= 256), s};
    endfunction

    // Issue one operation and observe it; inputs are scrambled right after the accepting edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output int busy_cnt, output int unstable,
                          output logic done_after, output logic [9:0] res);
        @(negedge w_clk);
        w_a = a; w_b = b; w_cin = c; w_start = 1'b1;
        @(negedge w_clk);
        w_start = 1'b0;
        w_a = 8'($urandom); w_b = 8'($urandom); w_cin = 1'($urandom);
        lat = -1; busy_cnt = 0; unstable = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge w_clk);
            if (r_done === 1'b1) begin
                lat = k;
                break;
            end
            if (r_busy === 1'b1) busy_cnt++;
            if (r_sum !== exp_sum || r_cout !== exp_cout || r_ovf !== exp_ovf) unstable++;
        end
        res = {r_ovf, r_cout, r_sum};
        @(negedge w_clk);
        done_after = r_done;
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0; w_start = 1'b1; w_a = 8'hFF; w_b = 8'hFF; w_cin = 1'b1;
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        n_checks++;
        if ({r_busy, r_done, r_sum, r_cout, r_ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     r_busy, r_done, r_sum, r_cout, r_ovf);
        end
        w_rst_n = 1'b1; w_start = 1'b0;
        @(negedge w_clk);
        n_checks++;
        if (r_busy !== 1'b0 || r_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", r_busy, r_done);
        end
        exp_sum = 8'h00; exp_cout = 1'b0; exp_ovf = 1'b0;
    endtask

    task automatic test_arith();
        logic [7:0] ta [5] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h80};
        logic [7:0] tb [5] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h80};
        logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] tx [5] = '{10'h000, 10'h100, 10'h280, 10'h100, 10'h300};
        int lat, busy_cnt, unstable;
        logic done_after;
        logic [9:0] res;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tc[i], lat, busy_cnt, unstable, done_after, res);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL arith_latency[%0d]: got %0d cycles, expected 8", i, lat);
            end
            n_checks++;
            if (busy_cnt !== 8) begin
                n_fail++;
                $display("FAIL arith_busy_len[%0d]: got %0d cycles, expected 8", i, busy_cnt);
            end
            n_checks++;
            if (done_after !== 1'b0) begin
                n_fail++;
                $display("FAIL arith_done_width[%0d]: done still %b one cycle later, expected 0", i, done_after);
            end
            n_checks++;
            if (unstable !== 0) begin
                n_fail++;
                $display("FAIL arith_hold[%0d]: previous result changed in %0d RUN cycles, expected 0", i, unstable);
            end
            n_checks++;
            if (res !== tx[i] || res !== model(ta[i], tb[i], tc[i])) begin
                n_fail++;
                $display("FAIL arith_result[%0d]: got ovf/cout/sum=%h, expected %h", i, res, tx[i]);
            end
            {exp_ovf, exp_cout, exp_sum} = tx[i];
        end
    endtask

    task automatic test_back_to_back();
        int found;
        @(negedge w_clk);
        w_a = 8'h03; w_b = 8'h04; w_cin = 1'b0; w_start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge w_clk);
            n_checks++;
            if (r_done !== ((k % 9) == 8) || r_busy !== ((k % 9) != 8)) begin
                n_fail++;
                $display("FAIL b2b_handshake[cycle %0d]: got busy=%b done=%b, expected busy=%b done=%b",
                         k, r_busy, r_done, ((k % 9) != 8), ((k % 9) == 8));
            end
            if ((k % 9) == 8) begin
                n_checks++;
                if ({r_ovf, r_cout, r_sum} !== model(8'h03, 8'h04, 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_result[cycle %0d]: got sum=%h cout=%b ovf=%b, expected sum=07 cout=0 ovf=0",
                             k, r_sum, r_cout, r_ovf);
                end
            end
        end
        w_start = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge w_clk);
            if (r_done === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL b2b_drain: got no done within 20 cycles, expected one");
        end
        @(negedge w_clk);
        exp_sum = 8'h07; exp_cout = 1'b0; exp_ovf = 1'b0;
    endtask

    task automatic test_abort();
        int dones, busies, lat, busy_cnt, unstable;
        logic done_after;
        logic [9:0] res;
        @(negedge w_clk);
        w_a = 8'h12; w_b = 8'h34; w_cin = 1'b0; w_start = 1'b1;
        @(negedge w_clk);
        w_start = 1'b0;
        repeat (3) @(negedge w_clk);
        n_checks++;
        if (r_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_running: got busy=%b before reset, expected 1", r_busy);
        end
        w_rst_n = 1'b0;
        @(negedge w_clk);
        n_checks++;
        if ({r_busy, r_done, r_sum, r_cout, r_ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     r_busy, r_done, r_sum, r_cout, r_ovf);
        end
        w_rst_n = 1'b1;
        exp_sum = 8'h00; exp_cout = 1'b0; exp_ovf = 1'b0;
        dones = 0; busies = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge w_clk);
            if (r_done === 1'b1) dones++;
            if (r_busy === 1'b1) busies++;
        end
        n_checks++;
        if (dones !== 0 || busies !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done and %0d busy cycles after abort, expected 0 0", dones, busies);
        end
        run_op(8'h12, 8'h34, 1'b0, lat, busy_cnt, unstable, done_after, res);
        n_checks++;
        if (lat !== 8 || res !== model(8'h12, 8'h34, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_restart: got latency=%0d ovf/cout/sum=%h, expected 8 and 046", lat, res);
        end
        {exp_ovf, exp_cout, exp_sum} = model(8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_random();
        int lat, busy_cnt, unstable;
        logic done_after;
        logic [9:0] res, exp;
        logic [7:0] a, b;
        logic c;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            exp = model(a, b, c);
            run_op(a, b, c, lat, busy_cnt, unstable, done_after, res);
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: %h+%h+%b got ovf/cout/sum=%h, expected %h", i, a, b, c, res, exp);
            end
            n_checks++;
            if (lat !== 8 || busy_cnt !== 8 || done_after !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: got latency=%0d busy=%0d done_after=%b, expected 8 8 0",
                         i, lat, busy_cnt, done_after);
            end
            n_checks++;
            if (unstable !== 0) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: previous result changed in %0d RUN cycles, expected 0", i, unstable);
            end
            {exp_ovf, exp_cout, exp_sum} = exp;
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before the summary line");
        $fatal(1);
    end

endmodule
